// File: rtl/trans_lane_rx_if.sv
// Lane receiver bundle: symbol stream in, Y/C pixel writes and frame/error status out.
// The master drives symbols; the slave is the receiver.
interface trans_lane_rx_if;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        PixWe;
    logic [15:0] PixAddr;
    logic [4:0]  PixY;
    logic [4:0]  PixC;
    logic        FrameStart;
    logic        FrameOdd;
    logic        FrameDone;
    logic        SymErr;
    logic        HdrErr;
    logic        LineErr;

    modport master (
        output RxData, RxValid,
        input  PixWe, PixAddr, PixY, PixC, FrameStart, FrameOdd, FrameDone,
               SymErr, HdrErr, LineErr
    );

    modport slave (
        input  RxData, RxValid,
        output PixWe, PixAddr, PixY, PixC, FrameStart, FrameOdd, FrameDone,
               SymErr, HdrErr, LineErr
    );
endinterface

// File: rtl/trans_lane_rx.sv
// Lane receiver: decodes marker/data symbols, frames them by header and line markers,
// and writes luma/chroma pairs into a frame buffer address space.
module trans_lane_rx #(
    parameter logic [23:0] FRAME1      = 24'haab155,
    parameter logic [23:0] FRAME0      = 24'haa8d55,
    parameter logic [15:0] HSYNC       = 16'ha355,
    parameter int          LINE_SYMS   = 80,
    parameter int          FRAME_PAIRS = 38400
) (
    input logic           Cclk,
    input logic           rstn,
    trans_lane_rx_if.slave lane
);

    localparam logic [15:0] LINE_LEN  = 16'(LINE_SYMS);
    localparam logic [15:0] LAST_PAIR = 16'(FRAME_PAIRS - 1);

    typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  run_q, run_d;
    logic        have_y_q, have_y_d;
    logic [4:0]  y_q, y_d;
    logic [15:0] pair_q, pair_d;
    logic [15:0] line_q, line_d;

    logic        pix_we_q, pix_we_d;
    logic [15:0] pix_addr_q, pix_addr_d;
    logic [4:0]  pix_y_q, pix_y_d;
    logic [4:0]  pix_c_q, pix_c_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_odd_q, frame_odd_d;
    logic        frame_done_q, frame_done_d;
    logic        sym_err_q, sym_err_d;
    logic        hdr_err_q, hdr_err_d;
    logic        line_err_q, line_err_d;

    logic       is_m1, is_m0, is_data, is_ill;
    logic [4:0] sym_val;
    logic       hdr_hit, hsync_hit;

    assign is_m1   = lane.RxValid && (lane.RxData == 8'hff);
    assign is_m0   = lane.RxValid && (lane.RxData == 8'h01);
    assign is_data = lane.RxValid && !lane.RxData[7] && (lane.RxData[1:0] == 2'b00);
    assign is_ill  = lane.RxValid && !is_m1 && !is_m0 && !is_data;
    assign sym_val = lane.RxData[6:2];

    // A run only counts as a marker when its exact length matches the pattern width.
    assign hdr_hit   = (run_q == 5'd24) && ((shift_q == FRAME1) || (shift_q == FRAME0));
    assign hsync_hit = (run_q == 5'd16) && (shift_q[15:0] == HSYNC);

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= HUNT;
            shift_q       <= '0;
            run_q         <= '0;
            have_y_q      <= 1'b0;
            y_q           <= '0;
            pair_q        <= '0;
            line_q        <= '0;
            pix_we_q      <= 1'b0;
            pix_addr_q    <= '0;
            pix_y_q       <= '0;
            pix_c_q       <= '0;
            frame_start_q <= 1'b0;
            frame_odd_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            sym_err_q     <= 1'b0;
            hdr_err_q     <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            run_q         <= run_d;
            have_y_q      <= have_y_d;
            y_q           <= y_d;
            pair_q        <= pair_d;
            line_q        <= line_d;
            pix_we_q      <= pix_we_d;
            pix_addr_q    <= pix_addr_d;
            pix_y_q       <= pix_y_d;
            pix_c_q       <= pix_c_d;
            frame_start_q <= frame_start_d;
            frame_odd_q   <= frame_odd_d;
            frame_done_q  <= frame_done_d;
            sym_err_q     <= sym_err_d;
            hdr_err_q     <= hdr_err_d;
            line_err_q    <= line_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        run_d         = run_q;
        have_y_d      = have_y_q;
        y_d           = y_q;
        pair_d        = pair_q;
        line_d        = line_q;
        pix_we_d      = 1'b0;
        pix_addr_d    = pix_addr_q;
        pix_y_d       = pix_y_q;
        pix_c_d       = pix_c_q;
        frame_start_d = 1'b0;
        frame_odd_d   = frame_odd_q;
        frame_done_d  = 1'b0;
        sym_err_d     = is_ill;
        hdr_err_d     = 1'b0;
        line_err_d    = 1'b0;

        if (is_m1 || is_m0) begin
            shift_d = {shift_q[22:0], is_m1};
            run_d   = (run_q == 5'd31) ? run_q : run_q + 5'd1;
        end

        if (is_data) begin
            shift_d = '0;
            run_d   = '0;
            if (hdr_hit) begin
                state_d       = DATA;
                frame_start_d = 1'b1;
                frame_odd_d   = (shift_q == FRAME1);
                pix_addr_d    = '0;
                pair_d        = '0;
                line_d        = 16'd1;
                have_y_d      = 1'b1;
                y_d           = sym_val;
            end else if (state_q == DATA) begin
                if (hsync_hit) begin
                    line_err_d = (line_q != LINE_LEN);
                    line_d     = 16'd1;
                    have_y_d   = 1'b1;
                    y_d        = sym_val;
                end else if (run_q != 5'd0) begin
                    hdr_err_d = 1'b1;
                    have_y_d  = 1'b0;
                    state_d   = HUNT;
                end else begin
                    line_d = (line_q == 16'hffff) ? line_q : line_q + 16'd1;
                    if (have_y_q) begin
                        pix_we_d   = 1'b1;
                        pix_y_d    = y_q;
                        pix_c_d    = sym_val;
                        pix_addr_d = pair_q;
                        pair_d     = pair_q + 16'd1;
                        have_y_d   = 1'b0;
                        // The last pair closes the frame; no address wrap is possible.
                        if (pair_q == LAST_PAIR) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                        end
                    end else begin
                        have_y_d = 1'b1;
                        y_d      = sym_val;
                    end
                end
            end
        end
    end

    assign lane.PixWe      = pix_we_q;
    assign lane.PixAddr    = pix_addr_q;
    assign lane.PixY       = pix_y_q;
    assign lane.PixC       = pix_c_q;
    assign lane.FrameStart = frame_start_q;
    assign lane.FrameOdd   = frame_odd_q;
    assign lane.FrameDone  = frame_done_q;
    assign lane.SymErr     = sym_err_q;
    assign lane.HdrErr     = hdr_err_q;
    assign lane.LineErr    = line_err_q;

endmodule
